// File: rtl/switch_key_debounce_pkg.sv
// Shared constants for the switch/key input path. The idle levels here are
// also the reset readdata of the downstream switch/key peripheral, so both
// sides take them from this package instead of repeating literals.
package switch_key_debounce_pkg;

   // Push-buttons are active-low: released reads as 1.
   localparam logic [3:0] KEY_IDLE = 4'hf;

   // Slide switches idle in the off position.
   localparam logic [3:0] SW_IDLE = 4'h0;

   // 10 ms of required stability at a 50 MHz clk.
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

   // Number of conditioned pad inputs: {switches, keys}.
   localparam int NUM_INPUTS = 8;

endpackage

// File: rtl/switch_key_debounce_bit.sv
// One debounced input: two-flop synchronizer followed by a stability
// counter. The level only moves after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive edges; any single cycle of
// agreement throws the accumulated count away.
//
// update is high during the cycle whose closing edge moves level, so a
// registered copy of it lines up with the new level.
module debounce_bit #(
   parameter int   DEBOUNCE_CYCLES = 1,
   parameter int   CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1),
   parameter logic IDLE            = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic update
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 s1;
   logic                 s2;
   logic [CNT_WIDTH-1:0] cnt;

   // Synchronizer; starts at idle so reset release never looks like a change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= IDLE;
         s2 <= IDLE;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   assign update = (s2 != level) && (cnt == CNT_LAST);

   // Stability counter and output level; count never passes CNT_LAST.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level <= IDLE;
         cnt   <= '0;
      end else if (s2 == level) begin
         cnt <= '0;
      end else if (update) begin
         level <= s2;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/switch_key_debounce.sv
// Input conditioning for the board's four push-buttons and four slide
// switches. Each pad is synchronized and debounced independently; changed
// pulses for one cycle after any edge on which at least one debounced level
// moved, so the peripheral sees a single event per press or flip even when
// several bits settle together. All outputs come straight from flops.
module switch_key_debounce
   import switch_key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] keys_raw,
   input  logic [3:0] switches_raw,
   output logic [3:0] keys,
   output logic [3:0] switches,
   output logic       changed
);

   localparam logic [NUM_INPUTS-1:0] IDLE_ALL = {SW_IDLE, KEY_IDLE};

   logic [NUM_INPUTS-1:0] raw_all;
   logic [NUM_INPUTS-1:0] level_all;
   logic [NUM_INPUTS-1:0] update_all;

   assign raw_all = {switches_raw, keys_raw};

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_WIDTH       (CNT_WIDTH),
         .IDLE            (IDLE_ALL[i])
      ) u_bit (
         .clk    (clk),
         .reset  (reset),
         .raw    (raw_all[i]),
         .level  (level_all[i]),
         .update (update_all[i])
      );
   end

   assign keys     = level_all[3:0];
   assign switches = level_all[7:4];

   // One strobe per update edge, however many bits moved on it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         changed <= 1'b0;
      end else begin
         changed <= |update_all;
      end
   end

endmodule

// File: tb/tb_switch_key_debounce.sv
// Bench for switch_key_debounce. Instance a runs with N = 4, instance b with
// N = 1. Rows are {raw inputs, expected outputs}; row i is driven before
// edge i and its expectation is pushed to the scoreboard, then popped and
// compared #1 after that edge.
module tb_switch_key_debounce;
   import switch_key_debounce_pkg::*;

   typedef struct packed {
      logic [3:0] k;
      logic [3:0] s;
      logic       c;
   } exp_t;

   typedef struct packed {
      logic       sel;
      logic [3:0] k_raw;
      logic [3:0] s_raw;
      exp_t       want;
   } vec_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;
   localparam exp_t IDLE_EXP = '{k: KEY_IDLE, s: SW_IDLE, c: 1'b0};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] k_raw_a = KEY_IDLE, s_raw_a = SW_IDLE;
   logic [3:0] k_raw_b = KEY_IDLE, s_raw_b = SW_IDLE;
   logic [3:0] k_a, s_a, k_b, s_b;
   logic       c_a, c_b;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   switch_key_debounce #(.DEBOUNCE_CYCLES(4)) dut_a (
      .clk          (clk),
      .reset        (reset),
      .keys_raw     (k_raw_a),
      .switches_raw (s_raw_a),
      .keys         (k_a),
      .switches     (s_a),
      .changed      (c_a)
   );

   switch_key_debounce #(.DEBOUNCE_CYCLES(1)) dut_b (
      .clk          (clk),
      .reset        (reset),
      .keys_raw     (k_raw_b),
      .switches     (s_b),
      .switches_raw (s_raw_b),
      .keys         (k_b),
      .changed      (c_b)
   );

   task automatic check(input string name, input exp_t act, input exp_t want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got keys=%h sw=%h chg=%b, expected keys=%h sw=%h chg=%b",
                  name, act.k, act.s, act.c, want.k, want.s, want.c);
      end
   endtask

   task automatic add(input logic sel, input logic [3:0] kr, input logic [3:0] sr,
                      input logic [3:0] ek, input logic [3:0] es, input logic ec);
      vec_t v;
      v.sel    = sel;
      v.k_raw  = kr;
      v.s_raw  = sr;
      v.want.k = ek;
      v.want.s = es;
      v.want.c = ec;
      tbl.push_back(v);
   endtask

   // Raw step held steady: old outputs for lat rows, then new level with a
   // single changed pulse, then new level quiet.
   task automatic add_step(input logic sel, input logic [3:0] kr, input logic [3:0] sr,
                           input logic [3:0] ok, input logic [3:0] os,
                           input logic [3:0] nk, input logic [3:0] ns, input int lat);
      for (int j = 0; j <= lat + 1; j++) begin
         if (j < lat) add(sel, kr, sr, ok, os, 1'b0);
         else         add(sel, kr, sr, nk, ns, j == lat);
      end
   endtask

   // Starts at a negedge, ends #1 after the last row's edge.
   task automatic run_table(input string name);
      exp_t act;
      exp_t want;
      @(negedge clk);
      foreach (tbl[i]) begin
         if (tbl[i].sel) begin
            k_raw_b = tbl[i].k_raw;
            s_raw_b = tbl[i].s_raw;
         end else begin
            k_raw_a = tbl[i].k_raw;
            s_raw_a = tbl[i].s_raw;
         end
         sb.push_back(tbl[i].want);
         @(posedge clk);
         #1;
         act  = tbl[i].sel ? exp_t'({k_b, s_b, c_b}) : exp_t'({k_a, s_a, c_a});
         want = sb.pop_front();
         check($sformatf("%s[%0d]", name, i), act, want);
         if (i != tbl.size() - 1) @(negedge clk);
      end
      tbl.delete();
   endtask

   initial begin
      // Reset with random pads: outputs idle at once.
      #3;
      k_raw_a = 4'($urandom);
      s_raw_a = 4'($urandom);
      k_raw_b = 4'($urandom);
      s_raw_b = 4'($urandom);
      reset = 1'b1;
      #1;
      check("reset_a", exp_t'({k_a, s_a, c_a}), IDLE_EXP);
      check("reset_b", exp_t'({k_b, s_b, c_b}), IDLE_EXP);
      k_raw_a = KEY_IDLE; s_raw_a = SW_IDLE;
      k_raw_b = KEY_IDLE; s_raw_b = SW_IDLE;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // No changed pulse after release with idle pads.
      for (int j = 0; j < 20; j++) add(SEL_A, 4'hf, 4'h0, 4'hf, 4'h0, 1'b0);
      run_table("post_reset");

      // Clean press and release of key 0.
      add_step(SEL_A, 4'he, 4'h0, 4'hf, 4'h0, 4'he, 4'h0, 5);
      add_step(SEL_A, 4'hf, 4'h0, 4'he, 4'h0, 4'hf, 4'h0, 5);
      run_table("press");

      // Switch 2 bounce: H H H L H H H L then H; only the final run of four
      // counts, landing on edge 13.
      for (int j = 0; j < 15; j++)
         add(SEL_A, 4'hf, (j == 3 || j == 7) ? 4'h0 : 4'h4,
             4'hf, (j >= 13) ? 4'h4 : 4'h0, j == 13);
      add_step(SEL_A, 4'hf, 4'h0, 4'hf, 4'h4, 4'hf, 4'h0, 5);
      run_table("bounce");

      // Key 1 low for N-1 cycles: filtered out.
      for (int j = 0; j < 9; j++)
         add(SEL_A, (j < 3) ? 4'hd : 4'hf, 4'h0, 4'hf, 4'h0, 1'b0);
      // Key 1 low for exactly N cycles: passes, then returns N edges later.
      for (int j = 0; j < 11; j++)
         add(SEL_A, (j < 4) ? 4'hd : 4'hf, 4'h0,
             (j >= 5 && j < 9) ? 4'hd : 4'hf, 4'h0, j == 5 || j == 9);
      run_table("pulse");

      // All eight bits move on the same edge: one pulse.
      add_step(SEL_A, 4'h0, 4'hf, 4'hf, 4'h0, 4'h0, 4'hf, 5);
      add_step(SEL_A, 4'hf, 4'h0, 4'h0, 4'hf, 4'hf, 4'h0, 5);
      run_table("simul");

      // Key 3 low, reset pulsed partway through the count.
      for (int j = 0; j < 4; j++) add(SEL_A, 4'h7, 4'h0, 4'hf, 4'h0, 1'b0);
      run_table("midcount_pre");
      reset = 1'b1;
      #1;
      check("midcount_reset", exp_t'({k_a, s_a, c_a}), IDLE_EXP);
      #1 reset = 1'b0;
      for (int j = 0; j < 6; j++)
         add(SEL_A, 4'h7, 4'h0, (j == 5) ? 4'h7 : 4'hf, 4'h0, j == 5);
      run_table("midcount_post");

      // Reset while keys and changed are active: all idle immediately.
      k_raw_a = 4'($urandom);
      s_raw_a = 4'($urandom);
      reset = 1'b1;
      #1;
      check("reset_active_a", exp_t'({k_a, s_a, c_a}), IDLE_EXP);
      check("reset_active_b", exp_t'({k_b, s_b, c_b}), IDLE_EXP);
      k_raw_a = KEY_IDLE; s_raw_a = SW_IDLE;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // N = 1: step reaches output at edge 2.
      for (int j = 0; j < 3; j++) add(SEL_B, 4'hf, 4'h0, 4'hf, 4'h0, 1'b0);
      add_step(SEL_B, 4'he, 4'h0, 4'hf, 4'h0, 4'he, 4'h0, 2);
      add_step(SEL_B, 4'hf, 4'h0, 4'he, 4'h0, 4'hf, 4'h0, 2);
      add_step(SEL_B, 4'hf, 4'h8, 4'hf, 4'h0, 4'hf, 4'h8, 2);
      add_step(SEL_B, 4'hf, 4'h0, 4'hf, 4'h8, 4'hf, 4'h0, 2);
      // One-cycle glitch on key 0 passes through, two back-to-back pulses.
      for (int j = 0; j < 6; j++)
         add(SEL_B, (j == 0) ? 4'he : 4'hf, 4'h0,
             (j == 2) ? 4'he : 4'hf, 4'h0, j == 2 || j == 3);
      run_table("n1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_key_debounce.md
# switch_key_debounce

Input conditioning stage for the board's four push-buttons and four slide switches. It synchronizes each raw pad signal into `clk`, rejects contact bounce with a per-bit stability counter, and presents clean levels. These levels drive the `keys`/`switches` inputs of the switch/key peripheral, so that the peripheral's change detection fires once per physical press or flip.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a synchronized input must differ from its stable value before the stable value updates (10 ms at 50 MHz). Legal range is ≥ 1.
- `CNT_WIDTH`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width. Never override below this value.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `keys_raw` in 4: push-button pads, asynchronous, active-low (1 = released).
- `switches_raw` in 4: slide-switch pads, asynchronous.
- `keys` out 4: debounced key levels.
- `switches` out 4: debounced switch levels.
- `changed` out 1: one-cycle strobe, high when any debounced bit updated on the previous edge.

## Operation
- Treat the 8 bits independently as `{switches_raw, keys_raw}`. Bit i uses idle value `IDLE[i]`, where `IDLE = 8'h0f` (keys released, switches off).
- Per bit, run two flops, `s1` then `s2`, as a synchronizer. Then apply this debounce rule:
  - `stable` is the output level, `cnt` is the counter.
  - Each edge, if `s2 == stable`, then `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= s2` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt+1`.
- Any single cycle of agreement (bounce back) discards accumulated count. No partial credit.
- `changed` is registered: it is the OR over bits of "stable updated this edge", so it goes high in the cycle after the update edge, for exactly one cycle per update edge. Simultaneous updates on several bits produce one pulse.
- The counter never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- Reset, asynchronous and at any time including mid-count:
  - `s1`, `s2` and `stable` go to `IDLE`.
  - All `cnt` go to 0.
  - `changed` goes to 0.
  - Outputs therefore read `keys = 4'hf`, `switches = 4'h0`, `changed = 0` immediately. No spurious `changed` pulse occurs on deassertion, because the synchronizers start at idle.
- Reset deassertion is assumed synchronized to `clk` upstream. The block does not resynchronize it.

## Timing
- Raw change set up before edge 0:
  - `s1` captures it at edge 0.
  - `s2` captures it at edge 1.
  - `stable` updates at edge 1+N, where N = `DEBOUNCE_CYCLES`.
  - `changed` is high from edge 1+N until edge 2+N.
- Total latency, raw to output, is N+2 rising edges, counting edge 0.
- With N = 1, `stable` follows `s2` one edge later. This is the minimum latency of 3 edges.
- A raw pulse shorter than N cycles at `s2` never reaches the output.
- Outputs are driven only by flops. There is no combinational path from inputs to outputs.

## Structure
- Shared constants header holds:
  - `KEY_IDLE = 4'hf`
  - `SW_IDLE = 4'h0`
  - the default `DEBOUNCE_CYCLES`
- Those idle values are the ones the downstream peripheral uses for its reset readdata. Both blocks must use the header, not literals.
- One sub-module, `debounce_bit`, with parameters `DEBOUNCE_CYCLES`, `CNT_WIDTH` and `IDLE` (1 bit). Its ports are `clk`, `reset`, `raw`, `level` and `update`.
- The top instantiates `debounce_bit` 8 times in a generate loop and registers the OR of the `update` signals into `changed`.

## Test plan
Run all scenarios with N = 4.
- **Reset values:** assert `reset` with random raw values → `keys = 4'hf`, `switches = 0`, `changed = 0` immediately. After deassertion with raw at idle → no `changed` pulse for 20 cycles.
- **Clean press:** `keys_raw[0]` goes 1→0 before edge 0 and is held → `keys = 4'he` after edge 5, `changed` high for exactly one cycle after edge 5.
- **Bounce reject:** `switches_raw[2]` toggles 1,0,1,0 with a 3-cycle high and 1-cycle low, then settles high → output rises only after 4 consecutive high `s2` cycles. Exactly one `changed` pulse.
- **Simultaneous bits:** `keys_raw = 4'h0` and `switches_raw = 4'hf` change on the same edge → all 8 outputs update on the same edge, with a single one-cycle `changed`.
- **Reset mid-count:** `keys_raw[3] = 0` for 3 stable `s2` cycles, then pulse `reset`, then keep the input held → outputs return to idle, and the full N+2 latency is required again from deassertion.
- **N = 1 instance:** a raw step → output updates at edge 2, `changed` high for one cycle after it. A 1-cycle raw glitch captured by `s1` propagates.
